// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: two-stage symbol decoder plus a word-alignment FSM
// that commands deserializer bit slips until control tokens arrive steadily.
module tmds_rx_channel #(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOCK_TOKENS    = 8,
  parameter int SLIP_SETTLE    = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] symbol_in,
  input  logic       symbol_valid,
  output logic       bitslip,
  output logic [3:0] slip_count,
  output logic       aligned,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       data_valid,
  output logic       sym_err
);

  typedef enum logic [1:0] {SEARCH, SLIP, CHECK, LOCKED} state_t;

  localparam logic [15:0] TMO_LAST    = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [7:0]  RUN_LAST    = 8'(LOCK_TOKENS - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SLIP_SETTLE - 1);

  logic [9:0]  s1_sym_reg;
  logic        s1_valid_reg;
  state_t      state_reg;
  logic [15:0] tmo_cnt_reg;
  logic [7:0]  run_cnt_reg;
  logic [7:0]  settle_cnt_reg;

  logic       is_tok;
  logic [1:0] tok_ctrl;
  logic [7:0] q_lo;
  logic [7:0] d;
  logic [3:0] ones;
  logic       use_xnor;
  logic       dec_err;

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (s1_sym_reg)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  assign q_lo = s1_sym_reg[9] ? ~s1_sym_reg[7:0] : s1_sym_reg[7:0];
  assign d[0] = q_lo[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign d[gi] = s1_sym_reg[8] ? (q_lo[gi] ^ q_lo[gi-1]) : ~(q_lo[gi] ^ q_lo[gi-1]);
  end

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) ones = ones + 4'(d[i]);
  end

  // An encoder picks XNOR (q[8]=0) exactly when this holds; any other pairing is corrupt.
  assign use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
  assign dec_err  = !is_tok && (s1_sym_reg[8] == use_xnor);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_sym_reg   <= '0;
      s1_valid_reg <= 1'b0;
      data_out     <= '0;
      ctrl_out     <= '0;
      de_out       <= 1'b0;
      data_valid   <= 1'b0;
      sym_err      <= 1'b0;
    end else begin
      s1_sym_reg   <= symbol_in;
      s1_valid_reg <= symbol_valid;
      data_valid   <= s1_valid_reg;
      if (s1_valid_reg) begin
        data_out <= d;
        de_out   <= !is_tok;
        sym_err  <= dec_err;
        if (is_tok) ctrl_out <= tok_ctrl;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= SEARCH;
      tmo_cnt_reg    <= '0;
      run_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
      bitslip        <= 1'b0;
      slip_count     <= '0;
      aligned        <= 1'b0;
    end else begin
      bitslip <= 1'b0;
      case (state_reg)
        SEARCH: begin
          if (s1_valid_reg) begin
            if (is_tok) begin
              state_reg   <= CHECK;
              run_cnt_reg <= 8'd1;
            end else if (tmo_cnt_reg == TMO_LAST) begin
              state_reg      <= SLIP;
              bitslip        <= 1'b1;
              slip_count     <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
              tmo_cnt_reg    <= '0;
              settle_cnt_reg <= '0;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            end
          end
        end
        SLIP: begin
          // Settling time runs on clk alone; the deserializer may stall valid meanwhile.
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_reg      <= SEARCH;
            settle_cnt_reg <= '0;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 8'd1;
          end
        end
        CHECK: begin
          if (s1_valid_reg) begin
            if (!is_tok) begin
              state_reg <= SEARCH;
            end else if (run_cnt_reg == RUN_LAST) begin
              state_reg <= LOCKED;
              aligned   <= 1'b1;
            end else begin
              run_cnt_reg <= run_cnt_reg + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (s1_valid_reg) begin
            if (is_tok) begin
              tmo_cnt_reg <= '0;
            end else if (tmo_cnt_reg == TMO_LAST) begin
              state_reg      <= SLIP;
              aligned        <= 1'b0;
              bitslip        <= 1'b1;
              slip_count     <= (slip_count == 4'd9) ? 4'd0 : slip_count + 4'd1;
              tmo_cnt_reg    <= '0;
              settle_cnt_reg <= '0;
            end else begin
              tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            end
          end
        end
        default: state_reg <= SEARCH;
      endcase
    end
  end

endmodule
